// File: rtl/alu_exec_pipe_pkg.sv
// Shared types for the dual-lane integer execute stage: ALU commands, operand
// kinds, pipeline stage records and width constants mirrored from the core config.
package alu_exec_pipe_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int DISPATCH_ADDR_WIDTH  = 1;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int ROB_ADDR_WIDTH       = 5;
    localparam int XLEN                 = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_cmd_t;

    typedef enum logic {
        OP_REG = 1'b0,
        OP_IMM = 1'b1
    } op_type_t;

    // Uop latched after register read; the ALU evaluates it during EX.
    typedef struct packed {
        logic                            valid;
        alu_cmd_t                        alu_cmd;
        logic [XLEN-1:0]                 op1;
        logic [XLEN-1:0]                 op2;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
        logic [DISPATCH_ADDR_WIDTH-1:0]  bank;
        logic [ROB_ADDR_WIDTH-1:0]       rob;
    } exec_stage_t;

    typedef struct packed {
        logic                            valid;
        logic [XLEN-1:0]                 result;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
        logic [DISPATCH_ADDR_WIDTH-1:0]  bank;
        logic [ROB_ADDR_WIDTH-1:0]       rob;
    } wb_stage_t;

    function automatic logic fwd_hit(
        input logic                            we,
        input logic [PHYS_REGS_ADDR_WIDTH-1:0] waddr,
        input logic [PHYS_REGS_ADDR_WIDTH-1:0] raddr
    );
        return we && (waddr == raddr);
    endfunction

endpackage

// File: rtl/alu_exec_pipe_if.sv
// Issue bundle, PRF read/write, ROB completion and wakeup signals of the execute stage.
// slave = execute pipe side, master = issue queue / PRF / ROB side.
interface alu_exec_pipe_if
    import alu_exec_pipe_pkg::*;
#(
    parameter int LANES   = DISPATCH_WIDTH,
    parameter int PRF_AW  = PHYS_REGS_ADDR_WIDTH,
    parameter int ROB_AW  = ROB_ADDR_WIDTH,
    parameter int BANK_AW = DISPATCH_ADDR_WIDTH
) ();

    logic     [LANES-1:0]              issue_valid;
    alu_cmd_t [LANES-1:0]              issue_alu_cmd;
    logic     [LANES-1:0][PRF_AW-1:0]  issue_op1;
    op_type_t [LANES-1:0]              issue_op2_type;
    logic     [LANES-1:0][XLEN-1:0]    issue_op2;
    logic     [LANES-1:0][PRF_AW-1:0]  issue_phys_rd;
    logic     [LANES-1:0][BANK_AW-1:0] issue_bank_addr;
    logic     [LANES-1:0][ROB_AW-1:0]  issue_rob_addr;

    logic     [LANES-1:0][PRF_AW-1:0]  prf_rs1_addr;
    logic     [LANES-1:0][XLEN-1:0]    prf_rs1_data;
    logic     [LANES-1:0][PRF_AW-1:0]  prf_rs2_addr;
    logic     [LANES-1:0][XLEN-1:0]    prf_rs2_data;

    logic     [LANES-1:0]              prf_we;
    logic     [LANES-1:0][PRF_AW-1:0]  prf_waddr;
    logic     [LANES-1:0][XLEN-1:0]    prf_wdata;

    logic     [LANES-1:0]              rob_done;
    logic     [LANES-1:0][BANK_AW-1:0] rob_bank_addr;
    logic     [LANES-1:0][ROB_AW-1:0]  rob_addr;

    logic     [LANES-1:0]              wake_valid;
    logic     [LANES-1:0][PRF_AW-1:0]  wake_phys_rd;

    modport master (
        output issue_valid, issue_alu_cmd, issue_op1, issue_op2_type, issue_op2,
               issue_phys_rd, issue_bank_addr, issue_rob_addr,
               prf_rs1_data, prf_rs2_data,
        input  prf_rs1_addr, prf_rs2_addr, prf_we, prf_waddr, prf_wdata,
               rob_done, rob_bank_addr, rob_addr, wake_valid, wake_phys_rd
    );

    modport slave (
        input  issue_valid, issue_alu_cmd, issue_op1, issue_op2_type, issue_op2,
               issue_phys_rd, issue_bank_addr, issue_rob_addr,
               prf_rs1_data, prf_rs2_data,
        output prf_rs1_addr, prf_rs2_addr, prf_we, prf_waddr, prf_wdata,
               rob_done, rob_bank_addr, rob_addr, wake_valid, wake_phys_rd
    );

endinterface

// File: rtl/alu_exec_pipe_alu_core.sv
// Combinational 32-bit integer ALU; shifts use b[4:0], compares yield 0/1,
// unknown commands yield 0.
module alu_exec_pipe_alu_core
    import alu_exec_pipe_pkg::*;
(
    input  alu_cmd_t        cmd,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (cmd)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_pipe.sv
// Dual-lane RR -> EX -> WB integer execute stage with WB->RR operand forwarding.
// Optional EXEC_FLUSH_EN adds a flush input that kills all in-flight uops.
module alu_exec_pipe
    import alu_exec_pipe_pkg::*;
#(
    parameter int LANES   = DISPATCH_WIDTH,
    parameter int PRF_AW  = PHYS_REGS_ADDR_WIDTH,
    parameter int ROB_AW  = ROB_ADDR_WIDTH,
    parameter int BANK_AW = DISPATCH_ADDR_WIDTH
) (
    input  logic clk,
    input  logic rst,
`ifdef EXEC_FLUSH_EN
    input  logic flush,
`endif
    alu_exec_pipe_if.slave bus
);

    exec_stage_t        rr_q    [LANES];
    wb_stage_t          ex_q    [LANES];
    logic [XLEN-1:0]    alu_res [LANES];
    logic [XLEN-1:0]    op1_val [LANES];
    logic [XLEN-1:0]    op2_val [LANES];
    logic [PRF_AW-1:0]  wb_rd   [LANES];
    logic [BANK_AW-1:0] wb_bank [LANES];
    logic [ROB_AW-1:0]  wb_rob  [LANES];
    logic [LANES-1:0]   wb_we;
    logic               kill;

`ifdef EXEC_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            wb_rd[l]   = ex_q[l].phys_rd;
            wb_bank[l] = ex_q[l].bank;
            wb_rob[l]  = ex_q[l].rob;
            wb_we[l]   = ex_q[l].valid && (ex_q[l].phys_rd != '0) && !kill;
        end
    end

    // PRF is written only at the end of the WB cycle, so a same-cycle reader
    // must take prf_wdata; the ascending scan lets the higher lane win a tie.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            op1_val[l] = bus.prf_rs1_data[l];
            op2_val[l] = bus.prf_rs2_data[l];
            for (int unsigned w = 0; w < LANES; w++) begin
                if (fwd_hit(wb_we[w], wb_rd[w], bus.issue_op1[l]))
                    op1_val[l] = ex_q[w].result;
                if (fwd_hit(wb_we[w], wb_rd[w], bus.issue_op2[l][PRF_AW-1:0]))
                    op2_val[l] = ex_q[w].result;
            end
            if (bus.issue_op2_type[l] == OP_IMM)
                op2_val[l] = bus.issue_op2[l];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        alu_exec_pipe_alu_core u_alu (
            .cmd    (rr_q[g].alu_cmd),
            .a      (rr_q[g].op1),
            .b      (rr_q[g].op2),
            .result (alu_res[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                rr_q[l] <= '0;
                ex_q[l] <= '0;
            end
        end else begin
            for (int unsigned l = 0; l < LANES; l++) begin
                rr_q[l].valid <= bus.issue_valid[l] && !kill;
                if (bus.issue_valid[l]) begin
                    rr_q[l].alu_cmd <= bus.issue_alu_cmd[l];
                    rr_q[l].op1     <= op1_val[l];
                    rr_q[l].op2     <= op2_val[l];
                    rr_q[l].phys_rd <= bus.issue_phys_rd[l];
                    rr_q[l].bank    <= bus.issue_bank_addr[l];
                    rr_q[l].rob     <= bus.issue_rob_addr[l];
                end
                ex_q[l].valid   <= rr_q[l].valid && !kill;
                ex_q[l].result  <= alu_res[l];
                ex_q[l].phys_rd <= rr_q[l].phys_rd;
                ex_q[l].bank    <= rr_q[l].bank;
                ex_q[l].rob     <= rr_q[l].rob;
            end
        end
    end

    // Wakeup comes from the uop currently in EX, one cycle ahead of its PRF write.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            bus.prf_rs1_addr[l]  = bus.issue_op1[l];
            bus.prf_rs2_addr[l]  = bus.issue_op2[l][PRF_AW-1:0];
            bus.prf_we[l]        = wb_we[l];
            bus.prf_waddr[l]     = wb_rd[l];
            bus.prf_wdata[l]     = ex_q[l].result;
            bus.rob_done[l]      = ex_q[l].valid && !kill;
            bus.rob_bank_addr[l] = wb_bank[l];
            bus.rob_addr[l]      = wb_rob[l];
            bus.wake_valid[l]    = rr_q[l].valid && (rr_q[l].phys_rd != '0) && !kill;
            bus.wake_phys_rd[l]  = rr_q[l].phys_rd;
        end
    end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed self-checking bench for alu_exec_pipe: reset, ALU ops, latency,
// forwarding, register-0 handling and (with EXEC_FLUSH_EN) flush.
module tb_alu_exec_pipe;
    import alu_exec_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
`ifdef EXEC_FLUSH_EN
    logic flush = 1'b0;
`endif
    int tests  = 0;
    int failed = 0;

    alu_exec_pipe_if bus ();

    alu_exec_pipe dut (
        .clk   (clk),
        .rst   (rst),
`ifdef EXEC_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_issue();
        bus.issue_valid     = '0;
        bus.issue_alu_cmd   = {ALU_ADD, ALU_ADD};
        bus.issue_op1       = '0;
        bus.issue_op2_type  = {OP_REG, OP_REG};
        bus.issue_op2       = '0;
        bus.issue_phys_rd   = '0;
        bus.issue_bank_addr = '0;
        bus.issue_rob_addr  = '0;
        bus.prf_rs1_data    = '0;
        bus.prf_rs2_data    = '0;
    endtask

    task automatic set_lane(input int lane, input alu_cmd_t cmd,
                            input logic [5:0] rs1, input logic [31:0] rs1_data,
                            input op_type_t t, input logic [31:0] op2, input logic [31:0] rs2_data,
                            input logic [5:0] rd, input logic bank, input logic [4:0] rob);
        bus.issue_valid[lane]     = 1'b1;
        bus.issue_alu_cmd[lane]   = cmd;
        bus.issue_op1[lane]       = rs1;
        bus.prf_rs1_data[lane]    = rs1_data;
        bus.issue_op2_type[lane]  = t;
        bus.issue_op2[lane]       = op2;
        bus.prf_rs2_data[lane]    = rs2_data;
        bus.issue_phys_rd[lane]   = rd;
        bus.issue_bank_addr[lane] = bank;
        bus.issue_rob_addr[lane]  = rob;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_issue();
        step();
        step();
        check("rst_prf_we", {30'b0, bus.prf_we}, 32'h0);
        check("rst_rob_done", {30'b0, bus.rob_done}, 32'h0);
        check("rst_wake", {30'b0, bus.wake_valid}, 32'h0);
        check("rst_wdata0", bus.prf_wdata[0], 32'h0);
        check("rst_rob_addr0", {27'b0, bus.rob_addr[0]}, 32'h0);
        rst = 1'b0;

        // reset while a lane0 uop sits in EX
        set_lane(0, ALU_ADD, 6'd1, 32'd1, OP_IMM, 32'd1, 32'd0, 6'd2, 1'b0, 5'd3);
        step();
        check("midrst_wake_before", {30'b0, bus.wake_valid}, 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_wake", {30'b0, bus.wake_valid}, 32'h0);
        check("midrst_rob_done", {30'b0, bus.rob_done}, 32'h0);
        clear_issue();
        step();
        check("midrst_prf_we", {30'b0, bus.prf_we}, 32'h0);
        rst = 1'b0;
        step();
        check("postrst_rob_done_a", {30'b0, bus.rob_done}, 32'h0);
        step();
        check("postrst_rob_done_b", {30'b0, bus.rob_done}, 32'h0);
        check("postrst_prf_we", {30'b0, bus.prf_we}, 32'h0);

        // lane0 ADD p3(5) + imm 7 -> p9
        set_lane(0, ALU_ADD, 6'd3, 32'd5, OP_IMM, 32'd7, 32'd0, 6'd9, 1'b1, 5'd17);
        check("rs1_addr0", {26'b0, bus.prf_rs1_addr[0]}, 32'd3);
        step();
        clear_issue();
        check("add_wake", {30'b0, bus.wake_valid}, 32'h1);
        check("add_wake_rd", {26'b0, bus.wake_phys_rd[0]}, 32'd9);
        check("add_we_early", {30'b0, bus.prf_we}, 32'h0);
        step();
        check("add_we", {30'b0, bus.prf_we}, 32'h1);
        check("add_waddr", {26'b0, bus.prf_waddr[0]}, 32'd9);
        check("add_wdata", bus.prf_wdata[0], 32'd12);
        check("add_rob_done", {30'b0, bus.rob_done}, 32'h1);
        check("add_rob_bank", {31'b0, bus.rob_bank_addr[0]}, 32'd1);
        check("add_rob_addr", {27'b0, bus.rob_addr[0]}, 32'd17);
        check("add_wake_after", {30'b0, bus.wake_valid}, 32'h0);
        step();
        check("add_we_one_cycle", {30'b0, bus.prf_we}, 32'h0);
        check("add_done_one_cycle", {30'b0, bus.rob_done}, 32'h0);

        // both lanes: SUB 0-1 -> p4, SLTU 1 < 0xFFFFFFFF -> p5
        set_lane(0, ALU_SUB, 6'd1, 32'd0, OP_REG, 32'd2, 32'd1, 6'd4, 1'b0, 5'd4);
        set_lane(1, ALU_SLTU, 6'd3, 32'd1, OP_REG, 32'd8, 32'hFFFF_FFFF, 6'd5, 1'b1, 5'd5);
        check("rs2_addr0", {26'b0, bus.prf_rs2_addr[0]}, 32'd2);
        step();
        clear_issue();
        step();
        check("dual_wdata0", bus.prf_wdata[0], 32'hFFFF_FFFF);
        check("dual_wdata1", bus.prf_wdata[1], 32'd1);
        check("dual_rob_done", {30'b0, bus.rob_done}, 32'h3);
        check("dual_we", {30'b0, bus.prf_we}, 32'h3);
        check("dual_waddr1", {26'b0, bus.prf_waddr[1]}, 32'd5);

        // back-to-back: SRA/SLT then undefined cmd/SLL
        set_lane(0, ALU_SRA, 6'd1, 32'h8000_0000, OP_IMM, 32'h24, 32'd0, 6'd13, 1'b0, 5'd6);
        set_lane(1, ALU_SLT, 6'd2, 32'hFFFF_FFFF, OP_REG, 32'd3, 32'd1, 6'd14, 1'b1, 5'd7);
        step();
        set_lane(0, alu_cmd_t'(4'hC), 6'd1, 32'd5, OP_IMM, 32'd3, 32'd0, 6'd15, 1'b0, 5'd8);
        set_lane(1, ALU_SLL, 6'd2, 32'd1, OP_IMM, 32'd31, 32'd0, 6'd16, 1'b1, 5'd9);
        step();
        clear_issue();
        check("sra_wdata", bus.prf_wdata[0], 32'hF800_0000);
        check("slt_wdata", bus.prf_wdata[1], 32'd1);
        step();
        check("undef_wdata", bus.prf_wdata[0], 32'd0);
        check("sll_wdata", bus.prf_wdata[1], 32'h8000_0000);
        check("b2b_rob_addr1", {27'b0, bus.rob_addr[1]}, 32'd9);

        // forwarding: producer p6 = 20, consumers read p6 with stale PRF data 0
        set_lane(0, ALU_ADD, 6'd1, 32'd15, OP_IMM, 32'd5, 32'd0, 6'd6, 1'b0, 5'd10);
        step();
        clear_issue();
        step();
        check("fwd_prod_wdata", bus.prf_wdata[0], 32'd20);
        set_lane(0, ALU_SUB, 6'd1, 32'd2, OP_REG, 32'd6, 32'd0, 6'd8, 1'b0, 5'd11);
        set_lane(1, ALU_ADD, 6'd6, 32'd0, OP_IMM, 32'd1, 32'd0, 6'd7, 1'b1, 5'd12);
        step();
        clear_issue();
        step();
        check("fwd_op2_lane0", bus.prf_wdata[0], 32'hFFFF_FFEE);
        check("fwd_op1_lane1", bus.prf_wdata[1], 32'd21);

        // destination p0: completes without PRF write, wakeup or forwarding
        set_lane(0, ALU_ADD, 6'd1, 32'd3, OP_IMM, 32'd4, 32'd0, 6'd0, 1'b0, 5'd13);
        step();
        clear_issue();
        check("p0_wake", {30'b0, bus.wake_valid}, 32'h0);
        step();
        check("p0_rob_done", {30'b0, bus.rob_done}, 32'h1);
        check("p0_prf_we", {30'b0, bus.prf_we}, 32'h0);
        check("p0_wdata", bus.prf_wdata[0], 32'd7);
        set_lane(0, ALU_ADD, 6'd0, 32'd0, OP_IMM, 32'd0, 32'd0, 6'd10, 1'b0, 5'd14);
        step();
        clear_issue();
        step();
        check("p0_nofwd_wdata", bus.prf_wdata[0], 32'd0);
        check("p0_nofwd_we", {30'b0, bus.prf_we}, 32'h1);
        check("p0_nofwd_waddr", {26'b0, bus.prf_waddr[0]}, 32'd10);

`ifdef EXEC_FLUSH_EN
        set_lane(0, ALU_ADD, 6'd1, 32'd1, OP_IMM, 32'd1, 32'd0, 6'd11, 1'b0, 5'd15);
        step();
        clear_issue();
        set_lane(1, ALU_ADD, 6'd1, 32'd2, OP_IMM, 32'd2, 32'd0, 6'd12, 1'b1, 5'd16);
        step();
        clear_issue();
        flush = 1'b1;
        set_lane(0, ALU_ADD, 6'd1, 32'd3, OP_IMM, 32'd3, 32'd0, 6'd13, 1'b0, 5'd18);
        #1;
        check("flush_rob_done", {30'b0, bus.rob_done}, 32'h0);
        check("flush_prf_we", {30'b0, bus.prf_we}, 32'h0);
        check("flush_wake", {30'b0, bus.wake_valid}, 32'h0);
        step();
        flush = 1'b0;
        clear_issue();
        check("postflush_rob_done_a", {30'b0, bus.rob_done}, 32'h0);
        check("postflush_wake", {30'b0, bus.wake_valid}, 32'h0);
        step();
        check("postflush_rob_done_b", {30'b0, bus.rob_done}, 32'h0);
        check("postflush_prf_we", {30'b0, bus.prf_we}, 32'h0);
        set_lane(0, ALU_OR, 6'd1, 32'hF0, OP_IMM, 32'h0F, 32'd0, 6'd20, 1'b0, 5'd19);
        step();
        clear_issue();
        step();
        check("afterflush_rob_done", {30'b0, bus.rob_done}, 32'h1);
        check("afterflush_wdata", bus.prf_wdata[0], 32'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
